// File: rtl/snake_pkg.sv
// Shared snake-game types: grid coordinates, default playfield size and the
// food_spawner search states.
package snake_pkg;

  localparam int unsigned GRID_W_DEF    = 20;
  localparam int unsigned GRID_H_DEF    = 15;
  localparam int unsigned MAX_TRIES_DEF = 8;

  typedef logic [4:0] coord_x_t;
  typedef logic [3:0] coord_y_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ROLL   = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_QUERY  = 3'd3,
    ST_SCAN   = 3'd4,
    ST_PLACE  = 3'd5
  } spawn_state_e;

endpackage

// File: rtl/food_scan_counter.sv
// Raster x/y walker over the playfield, x fastest; wrap_done flags the last cell.
module food_scan_counter
  import snake_pkg::*;
#(
  parameter int unsigned GRID_W = GRID_W_DEF,
  parameter int unsigned GRID_H = GRID_H_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     clear_i,
  input  logic     advance_i,
  output coord_x_t x_o,
  output coord_y_t y_o,
  output logic     wrap_done_o
);

  localparam coord_x_t X_LAST = coord_x_t'(GRID_W - 1);
  localparam coord_y_t Y_LAST = coord_y_t'(GRID_H - 1);

  coord_x_t x_q;
  coord_y_t y_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      x_q <= '0;
      y_q <= '0;
    end else if (advance_i) begin
      if (x_q == X_LAST) begin
        x_q <= '0;
        y_q <= (y_q == Y_LAST) ? '0 : y_q + 4'd1;
      end else begin
        x_q <= x_q + 5'd1;
      end
    end
  end

  assign x_o         = x_q;
  assign y_o         = y_q;
  assign wrap_done_o = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/food_spawner.sv
// Food placement search: random candidates checked against snake occupancy.
// FOOD_SCAN_EN enables the MAX_TRIES limit and the raster-scan fallback.
module food_spawner
  import snake_pkg::*;
#(
  parameter int unsigned GRID_W    = GRID_W_DEF,
  parameter int unsigned GRID_H    = GRID_H_DEF,
  parameter int unsigned MAX_TRIES = MAX_TRIES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spawn_req,
  input  logic [4:0] rng5,
  input  logic [3:0] rng4,
  output logic       rng_update,
  output logic       occ_query,
  output logic [4:0] occ_x,
  output logic [3:0] occ_y,
  input  logic       occ_valid,
  input  logic       occ_hit,
  output logic [4:0] food_x,
  output logic [3:0] food_y,
  output logic       food_valid,
  output logic       grid_full,
  output logic       busy
);

  if (GRID_W < 1 || GRID_W > 32 || GRID_H < 1 || GRID_H > 16 ||
      MAX_TRIES < 1 || MAX_TRIES > 255) begin : g_param_check
    $error("food_spawner: parameter out of range");
  end

  spawn_state_e state_q, state_d;
  coord_x_t     cand_x_q, cand_x_d, food_x_q, food_x_d;
  coord_y_t     cand_y_q, cand_y_d, food_y_q, food_y_d;
  logic         food_valid_q, food_valid_d;
  logic         try_fail;

`ifdef FOOD_SCAN_EN
  localparam logic [7:0] TRIES_LIM = 8'(MAX_TRIES);

  logic [7:0] tries_q, tries_d;
  logic       grid_full_q, grid_full_d;
  logic       scan_clear, scan_adv, scan_last;
  coord_x_t   scan_x;
  coord_y_t   scan_y;

  food_scan_counter #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_scan (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (scan_clear),
    .advance_i  (scan_adv),
    .x_o        (scan_x),
    .y_o        (scan_y),
    .wrap_done_o(scan_last)
  );
`endif

  always_comb begin
    state_d      = state_q;
    cand_x_d     = cand_x_q;
    cand_y_d     = cand_y_q;
    food_x_d     = food_x_q;
    food_y_d     = food_y_q;
    food_valid_d = food_valid_q;
    try_fail     = 1'b0;
`ifdef FOOD_SCAN_EN
    tries_d      = tries_q;
    grid_full_d  = grid_full_q;
    scan_clear   = 1'b0;
    scan_adv     = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: if (spawn_req) begin
        food_valid_d = 1'b0;
`ifdef FOOD_SCAN_EN
        grid_full_d  = 1'b0;
        tries_d      = '0;
`endif
        state_d      = ST_ROLL;
      end
      ST_ROLL: state_d = ST_SAMPLE;
      ST_SAMPLE: begin
        cand_x_d = rng5;
        cand_y_d = rng4;
        if (32'(rng5) >= GRID_W || 32'(rng4) >= GRID_H) try_fail = 1'b1;
        else                                              state_d  = ST_QUERY;
      end
      ST_QUERY: if (occ_valid) begin
        if (!occ_hit) state_d  = ST_PLACE;
        else          try_fail = 1'b1;
      end
`ifdef FOOD_SCAN_EN
      ST_SCAN: if (occ_valid) begin
        if (!occ_hit) begin
          cand_x_d = scan_x;
          cand_y_d = scan_y;
          state_d  = ST_PLACE;
        end else if (scan_last) begin
          grid_full_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          scan_adv = 1'b1;
        end
      end
`endif
      ST_PLACE: begin
        food_x_d     = cand_x_q;
        food_y_d     = cand_y_q;
        food_valid_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Rejected and occupied candidates share one retry path.
    if (try_fail) begin
`ifdef FOOD_SCAN_EN
      tries_d = tries_q + 8'd1;
      if (tries_d == TRIES_LIM) begin
        state_d    = ST_SCAN;
        scan_clear = 1'b1;
      end else begin
        state_d = ST_ROLL;
      end
`else
      state_d = ST_ROLL;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cand_x_q     <= '0;
      cand_y_q     <= '0;
      food_x_q     <= '0;
      food_y_q     <= '0;
      food_valid_q <= 1'b0;
`ifdef FOOD_SCAN_EN
      tries_q      <= '0;
      grid_full_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cand_x_q     <= cand_x_d;
      cand_y_q     <= cand_y_d;
      food_x_q     <= food_x_d;
      food_y_q     <= food_y_d;
      food_valid_q <= food_valid_d;
`ifdef FOOD_SCAN_EN
      tries_q      <= tries_d;
      grid_full_q  <= grid_full_d;
`endif
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign rng_update = (state_q == ST_ROLL);
  assign food_x     = food_x_q;
  assign food_y     = food_y_q;
  assign food_valid = food_valid_q;

`ifdef FOOD_SCAN_EN
  assign grid_full = grid_full_q;
  assign occ_query = (state_q == ST_QUERY) || (state_q == ST_SCAN);
  assign occ_x     = (state_q == ST_QUERY) ? cand_x_q : (state_q == ST_SCAN) ? scan_x : '0;
  assign occ_y     = (state_q == ST_QUERY) ? cand_y_q : (state_q == ST_SCAN) ? scan_y : '0;
`else
  assign grid_full = 1'b0;
  assign occ_query = (state_q == ST_QUERY);
  assign occ_x     = occ_query ? cand_x_q : '0;
  assign occ_y     = occ_query ? cand_y_q : '0;
`endif

endmodule

// File: tb/tb_food_spawner.sv
// Directed bench for food_spawner; scan scenarios run when FOOD_SCAN_EN is defined.
module tb_food_spawner;

  logic       clk = 1'b0;
  logic       rst_n, spawn_req, occ_valid, occ_hit;
  logic [4:0] rng5, occ_x, food_x;
  logic [3:0] rng4, occ_y, food_y;
  logic       rng_update, occ_query, food_valid, grid_full, busy;

  food_spawner #(.GRID_W(20), .GRID_H(15), .MAX_TRIES(8)) dut (
    .clk(clk), .rst_n(rst_n), .spawn_req(spawn_req), .rng5(rng5), .rng4(rng4),
    .rng_update(rng_update), .occ_query(occ_query), .occ_x(occ_x), .occ_y(occ_y),
    .occ_valid(occ_valid), .occ_hit(occ_hit), .food_x(food_x), .food_y(food_y),
    .food_valid(food_valid), .grid_full(grid_full), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Random-source model and occupancy responder, shared by all scenarios.
  logic [4:0] rx[8];
  logic [3:0] ry[8];
  int n_rng = 1, rng_idx = 0, rng_cnt = 0;
  int resp_wait = 0, hit_n = 0, qcount = 0, wcnt = 0;
  int first_rng = -1, first_q = -1, q_cycles = 0, unstable = 0, bad_q = 0;
  logic       prev_q = 1'b0, prev_v = 1'b0;
  logic [4:0] prev_x = '0;
  logic [3:0] prev_y = '0;

  initial begin
    occ_valid = 1'b0; occ_hit = 1'b0; rng5 = '0; rng4 = '0;
    forever begin
      @(negedge clk);
      if (rng_update) begin
        int idx;
        idx = (rng_idx < n_rng) ? rng_idx : n_rng - 1;
        rng5 = rx[idx];
        rng4 = ry[idx];
        rng_idx++;
        rng_cnt++;
        if (first_rng < 0) first_rng = cyc;
      end
      if (occ_query) begin
        q_cycles++;
        if (first_q < 0) first_q = cyc;
        if (occ_x >= 5'd20 || occ_y >= 4'd15) bad_q++;
        if (prev_q && !prev_v && (occ_x != prev_x || occ_y != prev_y)) unstable++;
        if (wcnt == resp_wait) begin
          occ_valid = 1'b1;
          occ_hit   = (qcount < hit_n);
          qcount++;
          wcnt = 0;
        end else begin
          occ_valid = 1'b0;
          occ_hit   = 1'b0;
          wcnt++;
        end
      end else begin
        occ_valid = 1'b0;
        occ_hit   = 1'b0;
        wcnt = 0;
      end
      prev_q = occ_query; prev_v = occ_valid; prev_x = occ_x; prev_y = occ_y;
    end
  end

  int base = 0;

  // Issue one request; lat = rising edge of food_valid/grid_full relative to the request edge.
  task automatic run_spawn(input int inject_at, output int lat);
    @(negedge clk);
    qcount = 0; rng_cnt = 0; rng_idx = 0; first_rng = -1; first_q = -1;
    q_cycles = 0; unstable = 0; bad_q = 0;
    spawn_req = 1'b1;
    @(negedge clk);
    spawn_req = 1'b0;
    base = cyc;
    lat = -1;
    for (int k = 0; k < 2000; k++) begin
      if (food_valid || grid_full) begin
        lat = cyc - base;
        break;
      end
      @(negedge clk);
      spawn_req = (inject_at >= 0) && (cyc - base == inject_at);
    end
    spawn_req = 1'b0;
    if (lat < 0) check("search_timeout", 1, 0);
  endtask

  function automatic int outs_packed();
    return int'({food_x, food_y, food_valid, grid_full, busy, rng_update,
                 occ_query, occ_x, occ_y});
  endfunction

  typedef struct {
    logic [4:0] x;
    logic [3:0] y;
    int         wait_c;
    int         lat;
  } vec_t;

  vec_t tbl[4];
  int   lat;

  initial begin
    tbl[0] = '{x: 5'd7,  y: 4'd6,  wait_c: 0, lat: 4};
    tbl[1] = '{x: 5'd19, y: 4'd14, wait_c: 0, lat: 4};
    tbl[2] = '{x: 5'd1,  y: 4'd1,  wait_c: 2, lat: 6};
    tbl[3] = '{x: 5'd10, y: 4'd5,  wait_c: 3, lat: 7};

    rst_n = 1'b0; spawn_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outs_packed(), 0);
    rst_n = 1'b1;

    // Reset while a lookup is outstanding.
    rx[0] = 5'd9; ry[0] = 4'd9; n_rng = 1; resp_wait = 50; hit_n = 0;
    @(negedge clk); spawn_req = 1'b1;
    @(negedge clk); spawn_req = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_search_query_active", int'(occ_query), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_mid_search_edge1", outs_packed(), 0);
    @(negedge clk);
    check("reset_mid_search_edge2", outs_packed(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_reset_idle", outs_packed(), 0);

    foreach (tbl[i]) begin
      rx[0] = tbl[i].x; ry[0] = tbl[i].y; n_rng = 1;
      resp_wait = tbl[i].wait_c; hit_n = 0;
      run_spawn(-1, lat);
      check($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
      check($sformatf("vec%0d_food", i), int'({food_x, food_y}), int'({tbl[i].x, tbl[i].y}));
      check($sformatf("vec%0d_rng_pulses", i), rng_cnt, 1);
      check($sformatf("vec%0d_rng_offset", i), first_rng - base, 0);
      check($sformatf("vec%0d_query_offset", i), first_q - base, 2);
      check($sformatf("vec%0d_query_cycles", i), q_cycles, tbl[i].wait_c + 1);
      check($sformatf("vec%0d_busy_after", i), int'(busy), 0);
    end

    // Out-of-range x then a free in-range cell.
    rx[0] = 5'd25; ry[0] = 4'd5; rx[1] = 5'd3; ry[1] = 4'd2; n_rng = 2;
    resp_wait = 0; hit_n = 0;
    run_spawn(-1, lat);
    check("oor_x_latency", lat, 6);
    check("oor_x_rng_pulses", rng_cnt, 2);
    check("oor_x_bad_queries", bad_q, 0);
    check("oor_x_queries", qcount, 1);
    check("oor_x_food", int'({food_x, food_y}), int'({5'd3, 4'd2}));

    // Out-of-range y (equal to GRID_H).
    rx[0] = 5'd5; ry[0] = 4'd15; rx[1] = 5'd3; ry[1] = 4'd2; n_rng = 2;
    run_spawn(-1, lat);
    check("oor_y_latency", lat, 6);
    check("oor_y_rng_pulses", rng_cnt, 2);
    check("oor_y_bad_queries", bad_q, 0);

    // Occupancy wait with a request injected while busy.
    rx[0] = 5'd12; ry[0] = 4'd9; n_rng = 1; resp_wait = 3; hit_n = 0;
    run_spawn(3, lat);
    check("wait_latency", lat, 7);
    check("wait_query_cycles", q_cycles, 4);
    check("wait_query_stable", unstable, 0);
    check("wait_rng_pulses", rng_cnt, 1);
    check("wait_food", int'({food_x, food_y}), int'({5'd12, 4'd9}));
    repeat (2) @(negedge clk);
    check("wait_inject_dropped", int'({busy, food_valid}), int'(2'b01));
    resp_wait = 0;

`ifdef FOOD_SCAN_EN
    // Eight hits, then scan: (0,0) and (1,0) hit, (2,0) free.
    rx[0] = 5'd5; ry[0] = 4'd5; n_rng = 1; hit_n = 10;
    run_spawn(-1, lat);
    check("scan_latency", lat, 28);
    check("scan_food", int'({food_x, food_y}), int'({5'd2, 4'd0}));
    check("scan_rng_pulses", rng_cnt, 8);
    check("scan_queries", qcount, 11);

    // Every cell occupied.
    hit_n = 1000000;
    run_spawn(-1, lat);
    check("full_latency", lat, 324);
    check("full_queries", qcount, 308);
    check("full_rng_pulses", rng_cnt, 8);
    @(negedge clk);
    check("full_flags", int'({grid_full, food_valid, busy}), int'(3'b100));
    repeat (3) @(negedge clk);
    check("full_sticky", int'(grid_full), 1);
    hit_n = 0; rx[0] = 5'd7; ry[0] = 4'd6;
    run_spawn(-1, lat);
    check("full_cleared_latency", lat, 4);
    check("full_cleared_flags", int'({grid_full, food_valid}), int'(2'b01));
`else
    // Without the scan fallback, hits keep rolling new candidates.
    rx[0] = 5'd4; ry[0] = 4'd4; n_rng = 1; hit_n = 10;
    run_spawn(-1, lat);
    check("retry_latency", lat, 34);
    check("retry_rng_pulses", rng_cnt, 11);
    check("retry_queries", qcount, 11);
    check("retry_food", int'({food_x, food_y}), int'({5'd4, 4'd4}));
    check("retry_grid_full", int'(grid_full), 0);
    hit_n = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
